// File: rtl/pc_unit.sv
// pc_unit: fetch PC sequencer with delay-slot redirect buffering, exception entry and return.
module pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [1:0]  npc_op,
    input  logic        ben,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_val,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        pend,
    output logic        adel
);
    typedef enum logic {IDLE, WAIT_DS} state_t;
    state_t      state;
    logic [31:0] buf_tgt, d_pc4, br_tgt, j_tgt, target;
    logic        redir;
    always_comb begin
        d_pc4  = d_pc + 32'd4;
        br_tgt = d_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
        j_tgt  = {d_pc4[31:28], index26, 2'b00};
        target = npc_op == 2'b00 ? br_tgt : npc_op == 2'b01 ? j_tgt : rs_val;
        redir  = br_valid && !stall &&
                 (npc_op == 2'b01 || npc_op == 2'b10 || (npc_op == 2'b00 && ben));
    end
    // exc_req and eret win over everything except reset and drop any buffered redirect
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= 32'h0000_3000;
            state   <= IDLE;
            pend    <= 1'b0;
            buf_tgt <= '0;
        end else if (exc_req) begin
            pc    <= 32'h0000_4180;
            state <= IDLE;
            pend  <= 1'b0;
        end else if (eret) begin
            pc    <= epc;
            state <= IDLE;
            pend  <= 1'b0;
        end else if (state == WAIT_DS) begin
            if (imem_ack) begin
                pc    <= buf_tgt;
                state <= IDLE;
                pend  <= 1'b0;
            end
        end else if (redir) begin
            if (imem_ack) pc <= target;
            else begin
                buf_tgt <= target;
                state   <= WAIT_DS;
                pend    <= 1'b1;
            end
        end else if (imem_ack) begin
            pc <= pc + 32'd4;
        end
    end
    assign adel = pc[1:0] != 2'b00;
endmodule
